demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter CNTW, default 8, width of each delivered-word counter.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset; one clock, no other reset.
REQ-005 inData  input  WIDTH  word offered by upstream.
REQ-006 inValid  input  1  upstream word valid.
REQ-007 inReady  output  1  router accepts word this cycle.
REQ-008 select  input  1  destination of offered word: 0 -> A, 1 -> B.
REQ-009 outAData  output  WIDTH  word held in slot A.
REQ-010 outAValid  output  1  slot A full.
REQ-011 outAReady  input  1  consumer A takes word this cycle.
REQ-012 outBData  output  WIDTH  word held in slot B.
REQ-013 outBValid  output  1  slot B full.
REQ-014 outBReady  input  1  consumer B takes word this cycle.
REQ-015 countA  output  CNTW  words delivered on A.
REQ-016 countB  output  CNTW  words delivered on B.

Function
REQ-017 Block is a registered, handshaked Demux: one single-entry slot per output (full flag + WIDTH data register).
REQ-018 Accept = inValid && inReady; drainX = outXValid && outXReady.
REQ-019 inReady combinational: select=0 -> !fullA || outAReady; select=1 -> !fullB || outBReady; independent of inValid.
REQ-020 On accept, inData written into slot chosen by select at that edge; outXValid rises next cycle (latency 1, no combinational in->out path for data or valid).
REQ-021 Unselected slot never written; its contents and full flag change only by its own drain.
REQ-022 Drain clears fullX at the edge unless same-edge accept targets X; then fullX stays 1 and outXData takes new word (full throughput, 1 word/cycle per output).
REQ-023 outXValid = fullX; outXData held stable while outXValid && !outXReady.
REQ-024 Slots A and B drain independently and may drain in the same cycle.
REQ-025 select sampled only at accept; changes while stalled allowed, inReady re-evaluated same cycle.
REQ-026 Word in slot not drained is never overwritten (no loss, no duplication).
REQ-027 countX increments by 1 on each drainX edge; wraps 2^CNTW-1 -> 0; no saturation.
REQ-028 Out-of-order across outputs permitted; order within one output equals acceptance order.

Reset
REQ-029 resetN low: immediately (no clock needed) fullA=fullB=0, outAData=outBData=0, countA=countB=0; outAValid=outBValid=0.
REQ-030 During and after reset inReady follows REQ-019 with empty slots, i.e. 1.
REQ-031 Reset mid-operation discards held words; no drain counted for them; first accept after release behaves per REQ-020.
REQ-032 Reset release synchronous-safe: first state change only on rising edge after resetN high.

Verification
REQ-033 Reset, then inValid=1, select=0, inData=0x1234, outAReady=0 -> next cycle outAValid=1, outAData=0x1234, outBValid=0, inReady(select=0)=0.
REQ-034 Slot A full, outAReady=0, offer select=1 data 0x00BB -> inReady=1, accepted; next cycle outBValid=1, outBData=0x00BB, outAData still 0x1234.
REQ-035 Slot A full, outAReady=1, inValid=1, select=0, inData=0x5555 every cycle for 10 cycles -> outAValid stays 1, data advances each cycle, countA=10, no word lost.
REQ-036 Drain A 257 times, CNTW=8 -> countA=1 (wrap), countB unchanged.
REQ-037 Both slots full, pulse resetN low asynchronously mid-cycle -> outAValid=outBValid=0 and counts 0 before next edge; inReady=1.
REQ-038 Random stimulus with random ready back-pressure -> per-output scoreboard order match, drained count equals countX mod 2^CNTW.

Source files
------------

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
//  Module      : demux_router
//  Description : Registered, handshaked 1-to-2 demultiplexer. Each output
//                owns a single-entry slot (full flag + data register). A
//                word offered on the input is steered by `select` into slot
//                A or slot B and appears on that output one cycle later.
//                Each output counts the words its consumer has taken.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock      in   rising-edge clock for all state
//    resetN     in   asynchronous active-low reset
//    inData     in   [WIDTH] word offered by upstream
//    inValid    in   upstream word valid
//    inReady    out  router accepts the offered word this cycle
//    select     in   destination of the offered word (0 -> A, 1 -> B)
//    outAData   out  [WIDTH] word held in slot A
//    outAValid  out  slot A full
//    outAReady  in   consumer A takes the word this cycle
//    outBData   out  [WIDTH] word held in slot B
//    outBValid  out  slot B full
//    outBReady  in   consumer B takes the word this cycle
//    countA     out  [CNTW] words delivered on A (wrapping)
//    countB     out  [CNTW] words delivered on B (wrapping)
// ============================================================================
module demux_router #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  input  logic             select,
  output logic [WIDTH-1:0] outAData,
  output logic             outAValid,
  input  logic             outAReady,
  output logic [WIDTH-1:0] outBData,
  output logic             outBValid,
  input  logic             outBReady,
  output logic [CNTW-1:0]  countA,
  output logic [CNTW-1:0]  countB
);

  localparam logic            c_SEL_A   = 1'b0;
  localparam logic            c_SEL_B   = 1'b1;
  localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // Slot state
  logic             r_full_a;
  logic             r_full_b;
  logic [WIDTH-1:0] r_data_a;
  logic [WIDTH-1:0] r_data_b;
  logic [CNTW-1:0]  r_count_a;
  logic [CNTW-1:0]  r_count_b;

  // Handshake terms
  logic w_room_a;
  logic w_room_b;
  logic w_accept;
  logic w_acc_a;
  logic w_acc_b;
  logic w_drain_a;
  logic w_drain_b;

  // A slot can take a word if it is empty, or if its current word leaves
  // at this same edge; that second term gives one word per cycle per output.
  assign w_room_a = !r_full_a || outAReady;
  assign w_room_b = !r_full_b || outBReady;

  // Ready depends only on the selected slot, never on inValid, so upstream
  // may legally wait for ready before raising valid.
  assign inReady  = (select == c_SEL_B) ? w_room_b : w_room_a;

  assign w_accept  = inValid && inReady;
  assign w_acc_a   = w_accept && (select == c_SEL_A);
  assign w_acc_b   = w_accept && (select == c_SEL_B);
  assign w_drain_a = r_full_a && outAReady;
  assign w_drain_b = r_full_b && outBReady;

  // --------------------------------------------------------------------------
  // Slot A. A same-edge accept takes priority over the drain for the full
  // flag: the old word leaves and the new one replaces it, so the slot
  // stays full.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_full_a  <= 1'b0;
      r_data_a  <= '0;
      r_count_a <= '0;
    end else begin
      if (w_acc_a) begin
        r_full_a <= 1'b1;
        r_data_a <= inData;
      end else if (w_drain_a) begin
        r_full_a <= 1'b0;
      end
      if (w_drain_a) begin
        r_count_a <= r_count_a + c_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slot B, identical behaviour to slot A and fully independent of it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_full_b  <= 1'b0;
      r_data_b  <= '0;
      r_count_b <= '0;
    end else begin
      if (w_acc_b) begin
        r_full_b <= 1'b1;
        r_data_b <= inData;
      end else if (w_drain_b) begin
        r_full_b <= 1'b0;
      end
      if (w_drain_b) begin
        r_count_b <= r_count_b + c_CNT_ONE;
      end
    end
  end

  // All outputs come straight from registers; no input reaches an output
  // data/valid combinationally.
  assign outAValid = r_full_a;
  assign outAData  = r_data_a;
  assign outBValid = r_full_b;
  assign outBData  = r_data_b;
  assign countA    = r_count_a;
  assign countB    = r_count_b;

  // --------------------------------------------------------------------------
  // Interface properties: a stalled word must hold still on its output.
  // --------------------------------------------------------------------------
  a_hold_a : assert property (@(posedge clock) disable iff (!resetN)
    (outAValid && !outAReady) |=> (outAValid && $stable(outAData)));

  a_hold_b : assert property (@(posedge clock) disable iff (!resetN)
    (outBValid && !outBReady) |=> (outBValid && $stable(outBData)));

endmodule : demux_router
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_router
//  Description : Self-checking bench for demux_router. Directed scenarios
//                for the reset state, basic routing, full-throughput
//                streaming, counter wrap and asynchronous reset, followed by
//                randomized traffic checked against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_router;

  localparam int WIDTH = 16;
  localparam int CNTW  = 8;
  localparam int CNT_MOD = 1 << CNTW;
  localparam int N_RAND  = 3000;

  logic             clock;
  logic             resetN;
  logic [WIDTH-1:0] inData;
  logic             inValid;
  logic             inReady;
  logic             select;
  logic [WIDTH-1:0] outAData;
  logic             outAValid;
  logic             outAReady;
  logic [WIDTH-1:0] outBData;
  logic             outBValid;
  logic             outBReady;
  logic [CNTW-1:0]  countA;
  logic [CNTW-1:0]  countB;

  int n_checks = 0;
  int n_errors = 0;

  demux_router #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .inData    (inData),
    .inValid   (inValid),
    .inReady   (inReady),
    .select    (select),
    .outAData  (outAData),
    .outAValid (outAValid),
    .outAReady (outAReady),
    .outBData  (outBData),
    .outBValid (outBValid),
    .outBReady (outBReady),
    .countA    (countA),
    .countB    (countB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    inValid   = 1'b0;
    inData    = '0;
    select    = 1'b0;
    outAReady = 1'b0;
    outBReady = 1'b0;
  endtask

  // Reference model: each output is a queue of accepted-but-undelivered
  // words; a slot holds at most one, so the queue length is the full flag.
  logic [WIDTH-1:0] qA[$];
  logic [WIDTH-1:0] qB[$];
  int delivA;
  int delivB;

  initial begin
    bit exp_rdy;
    bit dA, dB;

    idle_inputs();
    resetN = 1'b0;
    #2;
    // Reset state, no clock edge yet
    check_val("rst_validA", 32'(outAValid), 32'd0);
    check_val("rst_validB", 32'(outBValid), 32'd0);
    check_val("rst_cntA",   32'(countA),    32'd0);
    check_val("rst_cntB",   32'(countB),    32'd0);
    check_val("rst_ready",  32'(inReady),   32'd1);
    tick();
    tick();
    resetN = 1'b1;
    tick();

    // ---- Basic routing into A, then B while A is stalled ----
    inValid = 1'b1; select = 1'b0; inData = 16'h1234;
    tick();
    inValid = 1'b0;
    #1;
    check_val("a_valid",     32'(outAValid), 32'd1);
    check_val("a_data",      32'(outAData),  32'h1234);
    check_val("b_idle",      32'(outBValid), 32'd0);
    check_val("a_full_rdy0", 32'(inReady),   32'd0);

    select = 1'b1; inData = 16'h00BB; inValid = 1'b1;
    #1;
    check_val("b_rdy_while_a_full", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
    #1;
    check_val("b_valid",  32'(outBValid), 32'd1);
    check_val("b_data",   32'(outBData),  32'h00BB);
    check_val("a_kept",   32'(outAData),  32'h1234);
    check_val("a_still",  32'(outAValid), 32'd1);

    // Drain B once
    outBReady = 1'b1;
    tick();
    outBReady = 1'b0;
    #1;
    check_val("b_drained", 32'(outBValid), 32'd0);
    check_val("b_cnt1",    32'(countB),    32'd1);

    // ---- Full throughput on A: 10 back-to-back accept+drain cycles ----
    outAReady = 1'b1; inValid = 1'b1; select = 1'b0;
    for (int k = 0; k < 10; k++) begin
      inData = 16'h5500 + 16'(k);
      tick();
      check_val("stream_valid", 32'(outAValid), 32'd1);
      check_val("stream_data",  32'(outAData),  32'h5500 + 32'(k));
      check_val("stream_cnt",   32'(countA),    32'(k + 1));
    end
    inValid = 1'b0;
    tick();
    outAReady = 1'b0;
    #1;
    check_val("stream_last_cnt", 32'(countA),    32'd11);
    check_val("stream_empty",    32'(outAValid), 32'd0);

    // ---- Counter wrap: reset, one B delivery, then 257 A deliveries ----
    resetN = 1'b0;
    #1;
    check_val("mid_rst_cntA", 32'(countA), 32'd0);
    tick();
    resetN = 1'b1;
    tick();
    inValid = 1'b1; select = 1'b1; inData = 16'hB0B0; outBReady = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    outBReady = 1'b0;
    check_val("wrap_pre_cntB", 32'(countB), 32'd1);
    inValid = 1'b1; select = 1'b0; outAReady = 1'b1;
    for (int k = 0; k < 257; k++) begin
      inData = 16'(k);
      tick();
    end
    inValid = 1'b0;
    tick();
    outAReady = 1'b0;
    #1;
    check_val("wrap_cntA", 32'(countA), 32'd1);
    check_val("wrap_cntB", 32'(countB), 32'd1);

    // ---- Asynchronous reset with both slots full ----
    inValid = 1'b1; select = 1'b0; inData = 16'hAAAA;
    tick();
    select = 1'b1; inData = 16'hBBBB;
    tick();
    inValid = 1'b0;
    #1;
    check_val("pre_rst_fullA", 32'(outAValid), 32'd1);
    check_val("pre_rst_fullB", 32'(outBValid), 32'd1);
    #1;
    resetN = 1'b0;
    #1;
    check_val("arst_validA", 32'(outAValid), 32'd0);
    check_val("arst_validB", 32'(outBValid), 32'd0);
    check_val("arst_dataA",  32'(outAData),  32'd0);
    check_val("arst_dataB",  32'(outBData),  32'd0);
    check_val("arst_cntA",   32'(countA),    32'd0);
    check_val("arst_cntB",   32'(countB),    32'd0);
    check_val("arst_rdyB",   32'(inReady),   32'd1);
    select = 1'b0;
    #1;
    check_val("arst_rdyA",   32'(inReady),   32'd1);
    @(negedge clock);
    resetN = 1'b1;
    tick();
    check_val("post_rst_emptyA", 32'(outAValid), 32'd0);

    // ---- Randomized traffic against the queue model ----
    qA.delete(); qB.delete();
    delivA = 0; delivB = 0;
    for (int c = 0; c < N_RAND; c++) begin
      inValid   = ($urandom_range(0, 3) != 0);
      select    = 1'($urandom_range(0, 1));
      inData    = 16'($urandom);
      outAReady = ($urandom_range(0, 2) != 0);
      outBReady = ($urandom_range(0, 2) == 0);
      #1;
      check_val("r_validA", 32'(outAValid), 32'(qA.size() != 0));
      check_val("r_validB", 32'(outBValid), 32'(qB.size() != 0));
      if (qA.size() != 0) check_val("r_dataA", 32'(outAData), 32'(qA[0]));
      if (qB.size() != 0) check_val("r_dataB", 32'(outBData), 32'(qB[0]));
      check_val("r_cntA", 32'(countA), 32'(delivA % CNT_MOD));
      check_val("r_cntB", 32'(countB), 32'(delivB % CNT_MOD));
      exp_rdy = select ? (qB.size() == 0 || outBReady)
                       : (qA.size() == 0 || outAReady);
      check_val("r_ready", 32'(inReady), 32'(exp_rdy));

      // Apply what the coming edge does: departures first, then arrival.
      dA = (qA.size() != 0) && outAReady;
      dB = (qB.size() != 0) && outBReady;
      if (dA) begin void'(qA.pop_front()); delivA++; end
      if (dB) begin void'(qB.pop_front()); delivB++; end
      if (inValid && exp_rdy) begin
        if (select) qB.push_back(inData);
        else        qA.push_back(inData);
      end
      tick();
    end
    idle_inputs();
    #1;
    check_val("end_cntA", 32'(countA), 32'(delivA % CNT_MOD));
    check_val("end_cntB", 32'(countB), 32'(delivB % CNT_MOD));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_demux_router
`default_nettype wire
